serial_to_parallel_stream: RTL and testbench
============================================

Name: serial_to_parallel_stream

Overview:
- Next-generation deserializer. It accumulates N_BEATS input beats of LANE_W bits each into one OUT_W = LANE_W*N_BEATS word.
- Adds what the 1-bit version lacks:
  - valid/ready backpressure on both sides;
  - selectable beat ordering;
  - early termination of a partial word via in_last, reported through out_beats.
- Sits between serial front-ends (bit or nibble streams) and word-wide datapath consumers.

Parameters:
- LANE_W, 1, bits per input beat (>=1).
- N_BEATS, 8, beats per full output word (>=1).
- MSB_FIRST, 0, 0 = first beat lands in least-significant lane; 1 = first beat lands in most-significant lane.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  LANE_W  input beat.
- in_last  input  1  beat is the final one of the current word (forces emission).
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  OUT_W  assembled word.
- out_beats  output  CNT_W = $clog2(N_BEATS+1)  number of valid beats in out_data (1..N_BEATS).

Behaviour:
- Handshakes:
  - Beat accepted on a posedge with in_valid & in_ready.
  - Word transferred on a posedge with out_valid & out_ready.
- Reset (rst low, asynchronous):
  - out_valid=0, out_data=0, out_beats=0, in_ready=0.
  - Accumulator and beat count cleared.
  - in_ready rises the first cycle after rst deasserts.
  - Reset mid-word discards all partial data; no word is emitted.
- Accumulator states:
  - EMPTY: count=0.
  - FILL: 0<count<N_BEATS, no held word.
  - HELD: a completed word is waiting for the output register.
- Word completion:
  - Occurs on acceptance of beat number N_BEATS, or of any beat with in_last=1.
  - The completing beat is included in the word.
- Beat placement:
  - Beat index k (0-based within the word).
  - MSB_FIRST=0: lane k = bits [k*LANE_W +: LANE_W].
  - MSB_FIRST=1: lane k = bits [(N_BEATS-1-k)*LANE_W +: LANE_W].
- Partial words:
  - Unfilled lanes are zero.
  - out_beats = accepted beat count.
- Output register (single entry):
  - Loads the completed word when empty, or when draining the same cycle (out_valid & out_ready).
  - Otherwise the accumulator enters HELD and in_ready=0.
  - HELD exits on the cycle the output register drains: the held word moves over, and in_ready returns to 1 the following cycle.
- in_ready = !HELD (and out of reset); it is purely a function of registered state, with no combinational path from out_ready.
- Latency: the completing beat accepted at edge t gives out_valid=1 after edge t, when the output register is free.
- Throughput: sustained one beat per cycle with out_ready held at 1, no bubbles across word boundaries.
- Stability: out_data and out_beats hold stable while out_valid & !out_ready.
- Simultaneous events:
  - Draining and loading on the same edge keeps out_valid=1 with the new word.
  - in_last on the first beat yields out_beats=1.
  - in_last on beat N_BEATS yields a normal full word.
- in_data and in_last are ignored when in_valid=0.
- Widths: the beat counter is CNT_W wide and wraps to 0 at each completion; no arithmetic overflow is possible.
- N_BEATS=1 is legal: every beat is a complete word.

Decomposition:
- Package s2p_pkg:
  - function cnt_w(n) returning $clog2(n+1);
  - enum acc_state_t {EMPTY, FILL, HELD};
  - localparam-style helper lane_lsb(k, n_beats, msb_first).
- Sub-module s2p_out_reg: one-entry valid/ready register holding {out_beats, out_data}, with a load_ok output meaning empty-or-draining.

Test Plan:
- LANE_W=1, N_BEATS=8, MSB_FIRST=0, beats 1,0,1,1,0,0,0,1 with out_ready=1 -> out_data=8'h8D, out_beats=8, out_valid high exactly one cycle after the 8th beat.
- Same stream, MSB_FIRST=1 -> out_data=8'hB1.
- LANE_W=4, N_BEATS=4, beats 4'h1,4'h2,4'h3 with in_last on the 3rd -> out_data=16'h0321, out_beats=3; the next word starts at lane 0.
- Backpressure: out_ready=0, stream 16 continuous 1-bit beats -> first word in output register, second word HELD, in_ready=0 from the cycle after beat 16 until the first out_ready pulse. Words then emerge in order with no beat loss.
- Reset mid-word: assert rst after 5 beats -> outputs 0 immediately. 8 new beats of 8'hFF -> single word 8'hFF, out_beats=8.
- Random soak, 800 beats with random in_valid, out_ready and in_last (~5% in_last) -> scoreboard matches every word and out_beats; sum of out_beats equals accepted beats after drain.

Source files
------------

// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial_to_parallel_stream deserializer.
package s2p_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        HELD
    } acc_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Bit offset of beat k inside the assembled word for the chosen beat ordering.
    function automatic int lane_lsb(input int k, input int n_beats, input bit msb_first,
                                    input int lane_w = 1);
        return (msb_first ? (n_beats - 1 - k) : k) * lane_w;
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// One-entry valid/ready output register holding an assembled word and its beat count.
module s2p_out_reg #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CNT_W-1:0]  beats_i,
    input  logic              out_ready_i,
    output logic              load_ok_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  out_beats_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  beats_q, beats_d;

    assign load_ok_o   = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_beats_o = beats_q;

    // A load always wins over a drain so back-to-back words keep valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        beats_d = beats_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            beats_d = beats_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            beats_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: rtl/serial_to_parallel_stream.sv
// Deserializer: packs LANE_W-bit beats into N_BEATS-lane words with valid/ready on both sides.
module serial_to_parallel_stream
    import s2p_pkg::*;
#(
    parameter int LANE_W    = 1,
    parameter int N_BEATS   = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANE_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANE_W*N_BEATS-1:0]    out_data,
    output logic [cnt_w(N_BEATS)-1:0]    out_beats
);

    localparam int               OUT_W    = LANE_W * N_BEATS;
    localparam int               CNT_W    = cnt_w(N_BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BEATS - 1);

    acc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             alive_q;

    logic             accept;
    logic             load;
    logic             load_ok;
    logic [OUT_W-1:0] merged;
    logic [OUT_W-1:0] load_data;
    logic [CNT_W-1:0] load_beats;
    logic [CNT_W-1:0] cnt_inc;

    // in_ready comes only from registers, so out_ready never reaches it combinationally.
    assign in_ready = alive_q && (state_q != HELD);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign merged   = acc_q | (OUT_W'(in_data) << lane_lsb(int'(cnt_q), N_BEATS, MSB_FIRST, LANE_W));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        load       = 1'b0;
        load_data  = acc_q;
        load_beats = cnt_q;
        if (state_q == HELD) begin
            if (load_ok) begin
                load    = 1'b1;
                state_d = EMPTY;
                cnt_d   = '0;
                acc_d   = '0;
            end
        end else if (accept) begin
            if (in_last || (cnt_q == LAST_IDX)) begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_data  = merged;
                    load_beats = cnt_inc;
                    state_d    = EMPTY;
                    cnt_d      = '0;
                    acc_d      = '0;
                end else begin
                    state_d = HELD;
                    cnt_d   = cnt_inc;
                    acc_d   = merged;
                end
            end else begin
                state_d = FILL;
                cnt_d   = cnt_inc;
                acc_d   = merged;
            end
        end
    end

    // alive_q keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            acc_q   <= '0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            alive_q <= 1'b1;
        end
    end

    s2p_out_reg #(
        .DATA_W (OUT_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .data_i      (load_data),
        .beats_i     (load_beats),
        .out_ready_i (out_ready),
        .load_ok_o   (load_ok),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_beats_o (out_beats)
    );

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Directed and scoreboarded checks of serial_to_parallel_stream in three configurations.
module tb_serial_to_parallel_stream;

    logic        clk;
    logic        rst;

    logic        aValid, aLast, aOutReady;
    logic [0:0]  aData;
    logic        aReady, aOutValid;
    logic [7:0]  aOutData;
    logic [3:0]  aOutBeats;

    logic        bReady, bOutValid;
    logic [7:0]  bOutData;
    logic [3:0]  bOutBeats;

    logic        cValid, cLast, cOutReady;
    logic [3:0]  cData;
    logic        cReady, cOutValid;
    logic [15:0] cOutData;
    logic [2:0]  cOutBeats;

    int errCount   = 0;
    int checkCount = 0;

    int          accepted;
    int          poppedBeats;
    int          modCnt;
    logic [7:0]  modWord;
    logic [11:0] expQ[$];

    serial_to_parallel_stream #(.LANE_W(1), .N_BEATS(8), .MSB_FIRST(1'b0)) dutA (
        .clk(clk), .rst(rst), .in_valid(aValid), .in_ready(aReady), .in_data(aData),
        .in_last(aLast), .out_valid(aOutValid), .out_ready(aOutReady),
        .out_data(aOutData), .out_beats(aOutBeats)
    );

    serial_to_parallel_stream #(.LANE_W(1), .N_BEATS(8), .MSB_FIRST(1'b1)) dutB (
        .clk(clk), .rst(rst), .in_valid(aValid), .in_ready(bReady), .in_data(aData),
        .in_last(aLast), .out_valid(bOutValid), .out_ready(aOutReady),
        .out_data(bOutData), .out_beats(bOutBeats)
    );

    serial_to_parallel_stream #(.LANE_W(4), .N_BEATS(4), .MSB_FIRST(1'b0)) dutC (
        .clk(clk), .rst(rst), .in_valid(cValid), .in_ready(cReady), .in_data(cData),
        .in_last(cLast), .out_valid(cOutValid), .out_ready(cOutReady),
        .out_data(cOutData), .out_beats(cOutBeats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic data, input logic last);
        @(negedge clk);
        aValid = valid;
        aData  = data;
        aLast  = last;
    endtask

    task automatic applyLaneBeat(input logic valid, input logic [3:0] data, input logic last);
        @(negedge clk);
        cValid = valid;
        cData  = data;
        cLast  = last;
    endtask

    task automatic popCheck();
        logic [11:0] e;
        if (expQ.size() == 0) begin
            checkOutput("soakUnexpectedWord", 64'd1, 64'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("soakData", aOutData, e[7:0]);
            checkOutput("soakBeats", aOutBeats, e[11:8]);
        end
        poppedBeats += int'(aOutBeats);
    endtask

    task automatic soakStep(input logic forceLast, input logic allowInput);
        @(negedge clk);
        aValid    = allowInput && ($urandom_range(0, 3) != 0 || forceLast);
        aData     = 1'($urandom_range(0, 1));
        aLast     = forceLast || ($urandom_range(0, 99) < 5);
        aOutReady = forceLast || !allowInput || ($urandom_range(0, 3) != 0);
        #1;
        if (aOutValid && aOutReady) popCheck();
        if (aValid && aReady) begin
            modWord[modCnt] = aData[0];
            modCnt++;
            accepted++;
            if (aLast || modCnt == 8) begin
                expQ.push_back({4'(modCnt), modWord});
                modWord = '0;
                modCnt  = 0;
            end
        end
    endtask

    initial begin
        logic [7:0]  t1Beats;
        logic [15:0] bpBeats;
        logic [7:0]  preBeats;
        int          cycles;

        rst = 1'b0;
        aValid = 1'b0; aData = '0; aLast = 1'b0; aOutReady = 1'b1;
        cValid = 1'b0; cData = '0; cLast = 1'b0; cOutReady = 1'b1;

        #2;
        checkOutput("rstOutValid", aOutValid, 1'b0);
        checkOutput("rstOutData", aOutData, 8'h00);
        checkOutput("rstOutBeats", aOutBeats, 4'd0);
        checkOutput("rstInReady", aReady, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstInReadyRise", aReady, 1'b1);

        // Bit stream 1,0,1,1,0,0,0,1 in arrival order.
        t1Beats = 8'b1000_1101;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, t1Beats[i], 1'b0);
            if (i == 7) checkOutput("t1NoEarlyValid", aOutValid, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1Valid", aOutValid, 1'b1);
        checkOutput("t1DataLsb", aOutData, 8'h8D);
        checkOutput("t1Beats", aOutBeats, 4'd8);
        checkOutput("t1DataMsb", bOutData, 8'hB1);
        checkOutput("t1BeatsMsb", bOutBeats, 4'd8);
        @(negedge clk);
        checkOutput("t1Drained", aOutValid, 1'b0);

        applyLaneBeat(1'b1, 4'h1, 1'b0);
        applyLaneBeat(1'b1, 4'h2, 1'b0);
        applyLaneBeat(1'b1, 4'h3, 1'b1);
        applyLaneBeat(1'b1, 4'hA, 1'b0);
        checkOutput("t3PartialValid", cOutValid, 1'b1);
        checkOutput("t3PartialData", cOutData, 16'h0321);
        checkOutput("t3PartialBeats", cOutBeats, 3'd3);
        applyLaneBeat(1'b1, 4'hB, 1'b0);
        applyLaneBeat(1'b1, 4'hC, 1'b0);
        applyLaneBeat(1'b1, 4'hD, 1'b0);
        applyLaneBeat(1'b0, 4'h0, 1'b0);
        checkOutput("t3FullData", cOutData, 16'hDCBA);
        checkOutput("t3FullBeats", cOutBeats, 3'd4);

        // Word 1 = 8'h3C, word 2 = 8'hA5, sent LSB lane first.
        aOutReady = 1'b0;
        bpBeats = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, bpBeats[i], 1'b0);
            if (i == 8) checkOutput("bpFirstWord", aOutData, 8'h3C);
            if (i == 15) checkOutput("bpReadyBeforeHeld", aReady, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("bpHeldReady", aReady, 1'b0);
        checkOutput("bpHeldValid", aOutValid, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("bpStableData", aOutData, 8'h3C);
        checkOutput("bpStillHeld", aReady, 1'b0);
        aOutReady = 1'b1;
        @(negedge clk);
        checkOutput("bpSecondValid", aOutValid, 1'b1);
        checkOutput("bpSecondData", aOutData, 8'hA5);
        checkOutput("bpSecondBeats", aOutBeats, 4'd8);
        checkOutput("bpReadyBack", aReady, 1'b1);
        @(negedge clk);
        checkOutput("bpDrained", aOutValid, 1'b0);

        aOutReady = 1'b0;
        preBeats = 8'h81;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, preBeats[i], 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rmPreValid", aOutValid, 1'b1);
        checkOutput("rmPreData", aOutData, 8'h81);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rmOutValid", aOutValid, 1'b0);
        checkOutput("rmOutData", aOutData, 8'h00);
        checkOutput("rmOutBeats", aOutBeats, 4'd0);
        checkOutput("rmInReady", aReady, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        aOutReady = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rmWordValid", aOutValid, 1'b1);
        checkOutput("rmWordData", aOutData, 8'hFF);
        checkOutput("rmWordBeats", aOutBeats, 4'd8);
        @(negedge clk);
        checkOutput("rmSingleWord", aOutValid, 1'b0);

        accepted = 0; poppedBeats = 0; modCnt = 0; modWord = '0; cycles = 0;
        while (accepted < 800 && cycles < 20000) begin
            soakStep(1'b0, 1'b1);
            cycles++;
        end
        checkOutput("soakBudget", 64'(accepted >= 800), 64'd1);
        cycles = 0;
        while (modCnt != 0 && cycles < 50) begin
            soakStep(1'b1, 1'b1);
            cycles++;
        end
        checkOutput("soakFlush", 64'(modCnt), 64'd0);
        for (int i = 0; i < 20; i++) soakStep(1'b0, 1'b0);
        checkOutput("soakQueueEmpty", 64'(expQ.size()), 64'd0);
        checkOutput("soakBeatSum", 64'(poppedBeats), 64'(accepted));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
